rv_regfile_mp: RTL
==================

# rv_regfile_mp

Parametrised successor to the base integer register file: XLEN-wide, NREGS-deep, with NRP independent read ports. Read data is registered at the Decode-stage clock enable, with write-to-read forwarding and live tracking of held addresses. After reset, a clear sequencer zeroes the whole array before the block accepts traffic. Sits between Decode (read ports) and Writeback (write port) in the rv32i pipeline; NRP=3 is used for future fused/store-address paths.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, register count; power of two, ≥2; entry 0 is hard-wired zero
- NRP, 2, number of read ports, ≥1
- AW, $clog2(NREGS), address width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- rd_en  in  1  read-capture enable (Decode stage clock enable)
- rs_addr  in  NRP*AW  read addresses; port p occupies [p*AW +: AW]
- rs_rdata  out  NRP*XLEN  registered read data; port p occupies [p*XLEN +: XLEN]
- w_en  in  1  write enable (Writeback)
- rd  in  AW  write address
- rd_wdata  in  XLEN  write data
- ready  out  1  high once the array is cleared and the block accepts reads and writes

## Operation
- States:
  - CLEAR: entered whenever rst_n=0 at a clock edge.
  - RUN: entered from CLEAR when the last entry has been zeroed.
- Reset (rst_n=0 at an edge):
  - clear counter := 1, ready := 0.
  - All captured read addresses := 0 and all rs_rdata := 0.
  - Array contents are untouched on this edge.
- CLEAR, on each edge with rst_n=1:
  - x[cnt] := 0.
  - If cnt == NREGS-1: go to RUN and set ready := 1. Otherwise cnt := cnt+1.
  - w_en and rd_en are ignored; rs_rdata stays 0.
- RUN, write:
  - If w_en=1 and rd≠0: x[rd] := rd_wdata.
  - Writes to entry 0 are dropped.
- RUN, read capture when rd_en=1, per port p:
  - The captured address becomes rs_addr[p].
  - rs_rdata[p] becomes:
    - 0 if the address is 0;
    - else rd_wdata if w_en=1 and rd equals the address (same-edge forwarding);
    - else x[address].
- RUN, hold when rd_en=0, per port p:
  - The captured address and rs_rdata[p] are held.
  - Exception: if w_en=1 and rd equals the held address (≠0), rs_rdata[p] := rd_wdata. Held outputs always equal the current contents of their register.
- Ports are fully independent. Any number of ports may read the same address, all forwarded identically.
- Reset asserted mid-operation (any state): the next edge re-enters CLEAR and the full clear sequence restarts. Writes already in flight are lost.

## Timing
- Clear latency:
  - ready rises on the (NREGS-1)th rising edge with rst_n=1 after reset.
  - For NREGS=32: 31 edges. For NREGS=2: 1 edge.
- Read latency:
  - One edge. rs_rdata reflects the addresses presented with rd_en=1 at edge N, visible after edge N.
  - Write data presented at that same edge N is included via forwarding.
- Write latency: a write at edge N is visible to a capture at edge N (forwarded) and at any later edge (array).
- Reset values: ready=0; rs_rdata all 0.
- No combinational path from any input to any output.

## Test plan
- Reset clear:
  - Preload random data via RUN writes.
  - Pulse rst_n=0 for 1 cycle, then count edges until ready=1: must equal 31.
  - Then read all 32 entries on 2 ports: every rdata = 0.
- Basic write/read:
  - Write x5=0xDEADBEEF, then on a later edge capture rs_addr={p1:5, p0:0}.
  - Next cycle: p0=0x00000000, p1=0xDEADBEEF.
- Forwarding:
  - On the same edge, w_en=1, rd=7, rd_wdata=0x12345678, rd_en=1, both ports addr 7.
  - Both rdata = 0x12345678 after that edge.
- Held-address tracking:
  - Capture addr 9 (x9=0x1) with rd_en=1, then drop rd_en=0.
  - Write x9=0xA5A5A5A5 and x10=0x2.
  - rdata becomes 0xA5A5A5A5 one edge after the x9 write, and is unchanged by the x10 write.
- x0 protection:
  - Write rd=0, rd_wdata=0xFFFFFFFF with a same-edge capture of addr 0.
  - rdata=0, and a later read of x0 still returns 0.
- Reset mid-clear and during traffic:
  - Assert rst_n=0 at clear cycle 10, release it, and verify ready again takes 31 edges.
  - Writes issued with w_en=1 during CLEAR have no effect: reads after ready return 0.

Source files
------------

// File: rtl/rv_regfile_mp.sv
// Multi-read-port integer register file: registered reads with same-edge
// write forwarding, held-address tracking, and a post-reset clear sequencer.

module rv_regfile_rp #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            rd_en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] arr_data,
  input  logic            w_en,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_wdata,
  output logic [XLEN-1:0] rdata
);
  logic [AW-1:0] cap_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_addr <= '0;
      rdata    <= '0;
    end else if (run) begin
      if (rd_en) begin
        cap_addr <= addr;
        if (addr == '0)
          rdata <= '0;
        else if (w_en && rd == addr)
          rdata <= rd_wdata;
        else
          rdata <= arr_data;
      end else if (w_en && cap_addr != '0 && rd == cap_addr) begin
        // Held output tracks later writes to the register it shows.
        rdata <= rd_wdata;
      end
    end
  end
endmodule

module rv_regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [NRP*AW-1:0] rs_addr,
  output logic [NRP*XLEN-1:0] rs_rdata,
  input  logic              w_en,
  input  logic [AW-1:0]     rd,
  input  logic [XLEN-1:0]   rd_wdata,
  output logic              ready
);
  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= AW'(1);
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      if (cnt == AW'(NREGS - 1)) begin
        state <= RUN;
        ready <= 1'b1;
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  // Entry 0 is never written; readers mux it to zero.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR)
        mem[cnt] <= '0;
      else if (w_en && rd != '0)
        mem[rd] <= rd_wdata;
    end
  end

  logic [NRP-1:0][XLEN-1:0] arr_q;
  logic [NRP-1:0][XLEN-1:0] rdata_q;

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    assign arr_q[p] = mem[rs_addr[p*AW +: AW]];
    assign rs_rdata[p*XLEN +: XLEN] = rdata_q[p];

    rv_regfile_rp #(.XLEN(XLEN), .AW(AW)) u_rp (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (state == RUN),
      .rd_en    (rd_en),
      .addr     (rs_addr[p*AW +: AW]),
      .arr_data (arr_q[p]),
      .w_en     (w_en),
      .rd       (rd),
      .rd_wdata (rd_wdata),
      .rdata    (rdata_q[p])
    );
  end
endmodule
